// File: rtl/twdl_rom_server.sv
// twdl_rom_server: returns W = exp(-j*2*pi*k/N) for exponent k, k reduced mod N onto a quarter-wave cosine ROM.
// Latency: 8 cycles from request accept to rsp_val, one request per cycle sustained.
// Backpressure: global stall while rsp_val & !rsp_rdy; req_rdy = !stall and every stage holds its contents.
// Build option: define TWDL_CONJ_EN to add req_conj, which negates rsp_imag (conjugate twiddle for IFFT).
module twdl_rom_server #(
    parameter int wTw   = 16,
    parameter int wK    = 16,
    parameter int N_MAX = 1200,
    parameter int wTag  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [10:0]     cfg_len,
    input  logic [10:0]     cfg_stride,
    input  logic            req_val,
    output logic            req_rdy,
    input  logic [wK-1:0]   req_k,
    input  logic [wTag-1:0] req_tag,
`ifdef TWDL_CONJ_EN
    input  logic            req_conj,
`endif
    output logic            rsp_val,
    input  logic            rsp_rdy,
    output logic [wTw-1:0]  rsp_real,
    output logic [wTw-1:0]  rsp_imag,
    output logic [wTag-1:0] rsp_tag,
    output logic            rsp_err
);

    localparam int  Q   = N_MAX / 4;
    localparam int  IW  = $clog2(N_MAX);
    localparam int  QW  = $clog2(Q + 1);
    // Compare width large enough for k and for N<<5 with N up to 11 bits.
    localparam int  CW  = ((wK > 11) ? wK : 11) + 6;
    localparam int  FS  = (2 ** (wTw - 1)) - 1;
    localparam real PI  = 3.14159265358979323846;

    // Sideband carried alongside the data through every stage.
    typedef struct packed {
        logic            vld;
        logic            err;
        logic            conj;
        logic [wTag-1:0] tag;
    } meta_t;

    // Quarter-wave cosine entry, rounded half away from zero (all entries are >= 0).
    // The last entry is cos(pi/2) and is forced to exactly zero.
    function automatic logic signed [wTw-1:0] cos_entry(input int i);
        real x;
        if (i >= Q) begin
            return '0;
        end
        x = $cos(2.0 * PI * real'(i) / real'(N_MAX)) * real'(FS);
        return wTw'($rtoi(x + 0.5));
    endfunction

    // One conditional-subtract step of the modulo reduction: r -= N<<m when r >= N<<m.
    function automatic logic [wK-1:0] red_step(input logic [wK-1:0] r,
                                               input logic [10:0]   n,
                                               input int            m);
        logic [CW-1:0] lim;
        lim = CW'(n) << m;
        if (CW'(r) >= lim) begin
            return wK'(CW'(r) - lim);
        end
        return r;
    endfunction

    logic                   stall;
    logic                   req_conj_w;
    logic                   k_oor;

    meta_t                  meta_q [1:8];
    meta_t                  meta_d [1:8];
    logic [wK-1:0]          r_q [1:5];
    logic [wK-1:0]          r_d [1:5];
    logic [IW-1:0]          idx_q, idx_d;
    logic [1:0]             quad_map;
    logic [IW-1:0]          j_map;
    logic [1:0]             q7_q, q7_d;
    logic [QW-1:0]          a_q, a_d;
    logic [QW-1:0]          b_q, b_d;
    logic [1:0]             q8_q, q8_d;
    logic signed [wTw-1:0]  ca_q, ca_d;
    logic signed [wTw-1:0]  cb_q, cb_d;
    logic signed [wTw-1:0]  re_map, im_map;

    logic                   rsp_val_q, rsp_val_d;
    logic signed [wTw-1:0]  rsp_real_q, rsp_real_d;
    logic signed [wTw-1:0]  rsp_imag_q, rsp_imag_d;
    logic [wTag-1:0]        rsp_tag_q, rsp_tag_d;
    logic                   rsp_err_q, rsp_err_d;

    logic signed [wTw-1:0]  rom [0:Q];

    // Table contents are fixed at elaboration; two independent read ports index it.
    for (genvar g = 0; g <= Q; g++) begin : g_rom
        assign rom[g] = cos_entry(g);
    end

`ifdef TWDL_CONJ_EN
    assign req_conj_w = req_conj;
`else
    assign req_conj_w = 1'b0;
`endif

    // Only the output register can block; everything upstream freezes with it.
    assign stall   = rsp_val_q & ~rsp_rdy;
    assign req_rdy = ~stall;

    // Exponents at or beyond 32*N cannot be reduced by five steps and are flagged.
    assign k_oor = (CW'(req_k) >= (CW'(cfg_len) << 5));

    // Quadrant select and in-quadrant offset of the scaled table index.
    always_comb begin
        quad_map = 2'd0;
        j_map    = idx_q;
        if (idx_q >= IW'(3 * Q)) begin
            quad_map = 2'd3;
            j_map    = idx_q - IW'(3 * Q);
        end else if (idx_q >= IW'(2 * Q)) begin
            quad_map = 2'd2;
            j_map    = idx_q - IW'(2 * Q);
        end else if (idx_q >= IW'(Q)) begin
            quad_map = 2'd1;
            j_map    = idx_q - IW'(Q);
        end
    end

    // Rebuild the full-circle value from the two quarter-wave reads, then apply conjugate and error zeroing.
    always_comb begin
        re_map = ca_q;
        im_map = -cb_q;
        case (q8_q)
            2'd1: begin
                re_map = -cb_q;
                im_map = -ca_q;
            end
            2'd2: begin
                re_map = -ca_q;
                im_map = cb_q;
            end
            2'd3: begin
                re_map = cb_q;
                im_map = ca_q;
            end
            default: ;
        endcase
        if (meta_q[8].conj) begin
            im_map = -im_map;
        end
        if (meta_q[8].err) begin
            re_map = '0;
            im_map = '0;
        end
    end

    // Next-state for the whole pipe: hold everything on stall, otherwise advance one stage.
    always_comb begin
        meta_d     = meta_q;
        r_d        = r_q;
        idx_d      = idx_q;
        q7_d       = q7_q;
        a_d        = a_q;
        b_d        = b_q;
        q8_d       = q8_q;
        ca_d       = ca_q;
        cb_d       = cb_q;
        rsp_val_d  = rsp_val_q;
        rsp_real_d = rsp_real_q;
        rsp_imag_d = rsp_imag_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_err_d  = rsp_err_q;
        if (!stall) begin
            // Stages 1-5: reduction by N<<4 down to N<<0.
            meta_d[1] = '{vld: req_val, err: k_oor, conj: req_conj_w, tag: req_tag};
            r_d[1]    = red_step(req_k, cfg_len, 4);
            for (int s = 2; s <= 5; s++) begin
                meta_d[s] = meta_q[s-1];
                r_d[s]    = red_step(r_q[s-1], cfg_len, 5 - s);
            end
            // Stage 6: scale onto the master table; the true product is < N_MAX so IW bits suffice.
            meta_d[6] = meta_q[5];
            idx_d     = IW'(r_q[5]) * IW'(cfg_stride);
            // Stage 7: quadrant and the pair of mirrored table indices.
            meta_d[7] = meta_q[6];
            q7_d      = quad_map;
            a_d       = QW'(j_map);
            b_d       = QW'(Q) - QW'(j_map);
            // Stage 8: registered ROM read on both ports.
            meta_d[8] = meta_q[7];
            q8_d      = q7_q;
            ca_d      = rom[a_q];
            cb_d      = rom[b_q];
            // Output register.
            rsp_val_d  = meta_q[8].vld;
            rsp_tag_d  = meta_q[8].tag;
            rsp_err_d  = meta_q[8].err;
            rsp_real_d = re_map;
            rsp_imag_d = im_map;
        end
    end

    // Pipeline registers with synchronous active-low reset; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q     <= '{default: '0};
            r_q        <= '{default: '0};
            idx_q      <= '0;
            q7_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            q8_q       <= '0;
            ca_q       <= '0;
            cb_q       <= '0;
            rsp_val_q  <= 1'b0;
            rsp_real_q <= '0;
            rsp_imag_q <= '0;
            rsp_tag_q  <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            meta_q     <= meta_d;
            r_q        <= r_d;
            idx_q      <= idx_d;
            q7_q       <= q7_d;
            a_q        <= a_d;
            b_q        <= b_d;
            q8_q       <= q8_d;
            ca_q       <= ca_d;
            cb_q       <= cb_d;
            rsp_val_q  <= rsp_val_d;
            rsp_real_q <= rsp_real_d;
            rsp_imag_q <= rsp_imag_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_val  = rsp_val_q;
    assign rsp_real = rsp_real_q;
    assign rsp_imag = rsp_imag_q;
    assign rsp_tag  = rsp_tag_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_twdl_rom_server.sv
// tb_twdl_rom_server: scoreboard bench for twdl_rom_server.
// Expected responses are queued at request accept and compared in order at response handshake.
// Covers reset, quadrant values, wrap, range error, stall, random backpressure and mid-flight reset.
`timescale 1ns/1ps
module tb_twdl_rom_server;

    localparam int  N_MAX = 1200;
    localparam int  Q     = N_MAX / 4;
    localparam int  FS    = 32767;
    localparam real PI    = 3.14159265358979323846;

    typedef struct {
        int tag;
        int err;
        int re;
        int im;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] cfg_len;
    logic [10:0] cfg_stride;
    logic        req_val;
    logic        req_rdy;
    logic [15:0] req_k;
    logic [2:0]  req_tag;
`ifdef TWDL_CONJ_EN
    logic        req_conj;
`endif
    logic        rsp_val;
    logic        rsp_rdy;
    logic [15:0] rsp_real;
    logic [15:0] rsp_imag;
    logic [2:0]  rsp_tag;
    logic        rsp_err;

    exp_t sb [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   bp_en  = 0;
    int   ns [7] = '{1200, 600, 300, 150, 100, 48, 16};
    int   w, lat, kk, drv_k, stl_w, s_re, s_im, s_tag;

    twdl_rom_server #(.wTw(16), .wK(16), .N_MAX(N_MAX), .wTag(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_len    (cfg_len),
        .cfg_stride (cfg_stride),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_k      (req_k),
        .req_tag    (req_tag),
`ifdef TWDL_CONJ_EN
        .req_conj   (req_conj),
`endif
        .rsp_val    (rsp_val),
        .rsp_rdy    (rsp_rdy),
        .rsp_real   (rsp_real),
        .rsp_imag   (rsp_imag),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, obs, exp_v);
        end
    endtask

    // Quarter-wave cosine reference value.
    function automatic int cq(input int i);
        real x;
        if (i >= Q) return 0;
        x = $cos(2.0 * PI * real'(i) / real'(N_MAX)) * real'(FS);
        return $rtoi(x + 0.5);
    endfunction

    // Reference twiddle for exponent k at length n.
    function automatic exp_t model(input int k, input int n, input int tag);
        exp_t e;
        int   idx, q, j;
        e.tag = tag;
        e.err = 0;
        e.re  = 0;
        e.im  = 0;
        if (k >= 32 * n) begin
            e.err = 1;
            return e;
        end
        idx = (k % n) * (N_MAX / n);
        q   = idx / Q;
        j   = idx % Q;
        case (q)
            0: begin e.re =  cq(j);     e.im = -cq(Q - j); end
            1: begin e.re = -cq(Q - j); e.im = -cq(j);     end
            2: begin e.re = -cq(j);     e.im =  cq(Q - j); end
            default: begin e.re = cq(Q - j); e.im = cq(j); end
        endcase
        return e;
    endfunction

    // Drive one request (entered just after a rising edge); queue its expectation when accepted.
    task automatic send(input int k, input int tag, input exp_t e);
        int n;
        n = 0;
        req_val = 1'b1;
        req_k   = 16'(k);
        req_tag = 3'(tag);
        @(negedge clk);
        while (!req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) chk("accept_timeout", int'(req_rdy), 1);
        else sb.push_back(e);
        @(posedge clk);
        #1;
        req_val = 1'b0;
    endtask

    // Wait for all queued responses to come back.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Response monitor: in-order scoreboard compare on every handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_val && rsp_rdy) begin
            chk("rsp_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("rsp_tag",  int'(rsp_tag), mon_e.tag);
                chk("rsp_err",  int'(rsp_err), mon_e.err);
                chk("rsp_real", int'($signed(rsp_real)), mon_e.re);
                chk("rsp_imag", int'($signed(rsp_imag)), mon_e.im);
            end
        end
    end

    // Random response backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en != 0) rsp_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        cfg_len    = 11'd1200;
        cfg_stride = 11'd1;
        req_val    = 1'b0;
        req_k      = '0;
        req_tag    = '0;
`ifdef TWDL_CONJ_EN
        req_conj   = 1'b0;
`endif
        rsp_rdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_val",  int'(rsp_val), 0);
        chk("reset_rsp_real", int'(rsp_real), 0);
        chk("reset_rsp_imag", int'(rsp_imag), 0);
        chk("reset_rsp_tag",  int'(rsp_tag), 0);
        chk("reset_rsp_err",  int'(rsp_err), 0);
        chk("reset_req_rdy",  int'(req_rdy), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single k=0 request and its latency.
        send(0, 5, '{5, 0, FS, 0});
        lat = 0;
        while (!rsp_val && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 8);
        drain();

        // Quadrant boundaries back to back, including a wrap.
        send(300,  0, '{0, 0, 0, -FS});
        send(600,  1, '{1, 0, -FS, 0});
        send(900,  2, '{2, 0, 0, FS});
        send(1500, 3, '{3, 0, 0, -FS});
        w = 0;
        while (!rsp_val && w < 20) begin
            @(negedge clk);
            w++;
        end
        for (int c = 0; c < 4; c++) begin
            chk("consec_rsp_val", int'(rsp_val), 1);
            @(negedge clk);
        end
        drain();

        // Shorter transform length using the stride.
        cfg_len    = 11'd300;
        cfg_stride = 11'd4;
        send(75,  4, '{4, 0, 0, -FS});
        send(299, 5, model(1196, 1200, 5));
        drain();

        // Stream with a 4-cycle output stall.
        cfg_len    = 11'd1200;
        cfg_stride = 11'd1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    drv_k = $urandom_range(0, 38399);
                    send(drv_k, i % 8, model(drv_k, 1200, i % 8));
                end
            end
            begin
                stl_w = 0;
                while (!rsp_val && stl_w < 50) begin
                    @(posedge clk);
                    #1;
                    stl_w++;
                end
                chk("stall_rsp_seen", int'(rsp_val), 1);
                rsp_rdy = 1'b0;
                s_re  = int'($signed(rsp_real));
                s_im  = int'($signed(rsp_imag));
                s_tag = int'(rsp_tag);
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    chk("stall_req_rdy",  int'(req_rdy), 0);
                    chk("stall_rsp_val",  int'(rsp_val), 1);
                    chk("stall_rsp_real", int'($signed(rsp_real)), s_re);
                    chk("stall_rsp_imag", int'($signed(rsp_imag)), s_im);
                    chk("stall_rsp_tag",  int'(rsp_tag), s_tag);
                end
                @(posedge clk);
                #1;
                rsp_rdy = 1'b1;
            end
        join
        drain();

        // Range error at 32*N, then the largest in-range exponent.
        send(38400, 6, '{6, 1, 0, 0});
        send(38399, 7, model(1199, 1200, 7));
        drain();

        // Random exponents over several lengths under random backpressure.
        bp_en = 1;
        for (int c = 0; c < 7; c++) begin
            cfg_len    = 11'(ns[c]);
            cfg_stride = 11'(N_MAX / ns[c]);
            for (int i = 0; i < 12; i++) begin
                kk = $urandom_range(0, 32 * ns[c] + 3);
                send(kk, i % 8, model(kk, ns[c], i % 8));
            end
            drain();
        end
        bp_en = 0;
        rsp_rdy = 1'b1;
        cfg_len    = 11'd1200;
        cfg_stride = 11'd1;
        @(posedge clk);
        #1;

        // Reset with five requests in flight: nothing may come out.
        for (int i = 0; i < 5; i++) begin
            send(100 * (i + 1), i, model(100 * (i + 1), 1200, i));
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        chk("midrst_rsp_val", int'(rsp_val), 0);
        chk("midrst_req_rdy", int'(req_rdy), 1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("midrst_no_rsp", int'(rsp_val), 0);
        end
        @(posedge clk);
        #1;
        send(1, 2, model(1, 1200, 2));
        drain();

`ifdef TWDL_CONJ_EN
        req_conj = 1'b1;
        send(300, 1, '{1, 0, 0, FS});
        send(38400, 2, '{2, 1, 0, 0});
        req_conj = 1'b0;
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
